// File: rtl/lcd_bus_scheduler_pkg.sv
// Shared types, constants and helpers for the character LCD bus scheduler.
// Imported by the arbiter and the scheduler top.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] HOME         = 8'h02;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DISP_ON_CUR  = 8'h0E;
  localparam logic [7:0] FUNC_8BIT_2L = 8'h38;

  // Clear (0x01) and home (0x02/0x03) need the controller's long execution time
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] db
  );
    return !rs && (db[7:2] == 6'd0) && (db != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Requester handshake plus LCD pin bundle.
// The scheduler takes the master side; requesters/bench take the slave side.
interface lcd_bus_if;
  logic [1:0] req;
  logic       rs0;
  logic [7:0] db0;
  logic       rs1;
  logic [7:0] db1;
  logic [1:0] gnt;
  logic       busy;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] db;

  modport master (
    input  req, rs0, db0, rs1, db1,
    output gnt, busy, rs, rw, en, db
  );

  modport slave (
    output req, rs0, db0, rs1, db1,
    input  gnt, busy, rs, rw, en, db
  );
endinterface

// File: rtl/lcd_bus_scheduler_arb.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to the pointer, and the pointer moves away from each accepted winner.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win,
  output logic       idx
);

  logic ptr;

  always_comb begin
    idx = 1'b0;
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b01): idx = 1'b0;
      (req == 2'b10): idx = 1'b1;
      (req == 2'b11): idx = ptr;
      default:        idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      win = idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= ~idx;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Timed, handshaked HD44780 bus master shared by two requesters.
// Each write runs setup, enable pulse, hold and execution wait phases.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 4,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic  clk,
  input  logic  rst,
  lcd_bus_if.master bus
);

  localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_L    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_L  = CNT_W'(LONG_WAIT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             en_q, en_d;

  logic [1:0]       win;
  logic             idx;
  logic             take;
  logic             cnt_zero;

  lcd_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.req),
    .take (take),
    .win  (win),
    .idx  (idx)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    busy_d  = busy_q;
    rs_d    = rs_q;
    db_d    = db_q;
    en_d    = en_q;
    take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          take    = 1'b1;
          gnt_d   = win;
          busy_d  = 1'b1;
          rs_d    = idx ? bus.rs1 : bus.rs0;
          db_d    = idx ? bus.db1 : bus.db0;
          cnt_d   = SETUP_L;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          en_d    = 1'b1;
          cnt_d   = EN_L;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          en_d    = 1'b0;
          cnt_d   = HOLD_L;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          cnt_d   = is_long_cmd(rs_q, db_q) ? LONG_L : WAIT_L;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Async reset also kills an in-flight enable pulse without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      en_q    <= en_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.rs   = rs_q;
  assign bus.rw   = 1'b0;
  assign bus.en   = en_q;
  assign bus.db   = db_q;

endmodule
